// File: rtl/ppm_frame_decoder.sv
// PPM frame decoder: pops pulse words from the receiver buffer, pairs high/low
// intervals into periods, finds the sync gap and commits whole frames to a
// readable channel bank. Optional feature macro: PPM_FAILSAFE_EN (load FAILSAFE on signal loss).
module ppm_frame_decoder #(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned MIN_CH    = 4,
  parameter int unsigned SYNC_MIN  = 300000,
  parameter int unsigned PULSE_MIN = 80000,
  parameter int unsigned PULSE_MAX = 250000,
  parameter int unsigned TIMEOUT   = 5000000,
  parameter int unsigned FAILSAFE  = 150000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic [31:0] pulse_data,
  output logic        rd,
  input  logic [3:0]  ch_sel,
  output logic [31:0] ch_value,
  output logic [4:0]  ch_count,
  output logic        frame_valid,
  output logic        new_frame,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  localparam logic [31:0] SYNC_C  = 32'(SYNC_MIN);
  localparam logic [31:0] PMIN_C  = 32'(PULSE_MIN);
  localparam logic [31:0] PMAX_C  = 32'(PULSE_MAX);
  localparam logic [31:0] TO_C    = 32'(TIMEOUT);
  localparam logic [4:0]  NUM_C   = 5'(NUM_CH);
  localparam logic [4:0]  MIN_C   = 5'(MIN_CH);
  localparam logic [31:0] PER_MAX = 32'h7FFF_FFFF;

  if (NUM_CH < 1 || NUM_CH > 16 || MIN_CH > NUM_CH || PULSE_MIN > PULSE_MAX ||
      TIMEOUT == 0 || FAILSAFE > 32'h7FFF_FFFF) begin : g_bad_cfg
    $error("ppm_frame_decoder: invalid parameter set");
  end

  typedef enum logic {F_IDLE, F_CAP}   fetch_t;
  typedef enum logic {FR_HUNT, FR_RUN} frame_t;

  fetch_t      f_state, f_next;
  frame_t      fr_state, fr_next;
  logic        rd_en;
  logic        capture;

  logic [30:0] hi;
  logic        hi_ok, hi_ok_next, hi_we;
  logic [4:0]  idx, idx_next;
  logic        shadow_we, commit, err_inc;
  logic [31:0] shadow [NUM_CH];
  logic [31:0] bank   [NUM_CH];

  logic        w_lvl;
  logic [30:0] w_len;
  logic [31:0] sum, period;
  logic        is_sync, in_range;

  logic [31:0] idle_cnt;
  logic        timeout_hit;
  logic [31:0] sel_val;

  // ---------------------------------------------------------------- fetch
  // rd_en keeps rd low while reset is held, since rd is decoded combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_state <= F_IDLE;
      rd_en   <= 1'b0;
    end else begin
      f_state <= f_next;
      rd_en   <= 1'b1;
    end
  end

  always_comb begin
    f_next = f_state;
    rd     = 1'b0;
    case (f_state)
      F_IDLE: begin
        if (rdy && rd_en) begin
          rd     = 1'b1;
          f_next = F_CAP;
        end
      end
      F_CAP:   f_next = F_IDLE;
      default: f_next = F_IDLE;
    endcase
  end

  assign capture = (f_state == F_CAP);

  // ---------------------------------------------------------------- word decode
  assign w_lvl    = pulse_data[31];
  assign w_len    = pulse_data[30:0];
  assign sum      = {1'b0, hi} + {1'b0, w_len};
  assign period   = sum[31] ? PER_MAX : sum;
  assign is_sync  = (period >= SYNC_C);
  assign in_range = (period >= PMIN_C) && (period <= PMAX_C);

  // ---------------------------------------------------------------- signal-loss timer
  assign timeout_hit = !capture && (idle_cnt == TO_C - 32'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (capture) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_C) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------- frame FSM
  always_comb begin
    fr_next    = fr_state;
    hi_ok_next = hi_ok;
    idx_next   = idx;
    hi_we      = 1'b0;
    shadow_we  = 1'b0;
    commit     = 1'b0;
    err_inc    = 1'b0;
    if (capture) begin
      if (w_lvl && !hi_ok) begin
        hi_we      = 1'b1;
        hi_ok_next = 1'b1;
      end else if (!w_lvl && hi_ok) begin
        hi_ok_next = 1'b0;
        if (is_sync) begin
          // A sync always re-arms RUN; only a long enough frame commits.
          if (fr_state == FR_RUN) begin
            if (idx >= MIN_C) commit  = 1'b1;
            else              err_inc = 1'b1;
          end
          idx_next = '0;
          fr_next  = FR_RUN;
        end else if (fr_state == FR_RUN) begin
          if (in_range && idx < NUM_C) begin
            shadow_we = 1'b1;
            idx_next  = idx + 5'd1;
          end else begin
            err_inc = 1'b1;
            fr_next = FR_HUNT;
          end
        end
      end else begin
        err_inc    = 1'b1;
        hi_ok_next = 1'b0;
        fr_next    = FR_HUNT;
      end
    end else if (timeout_hit) begin
      fr_next    = FR_HUNT;
      hi_ok_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fr_state    <= FR_HUNT;
      hi          <= '0;
      hi_ok       <= 1'b0;
      idx         <= '0;
      ch_count    <= '0;
      frame_valid <= 1'b0;
      new_frame   <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        bank[i]   <= '0;
      end
    end else begin
      fr_state  <= fr_next;
      hi_ok     <= hi_ok_next;
      idx       <= idx_next;
      new_frame <= commit;
      if (hi_we) hi <= w_len;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (shadow_we && idx == 5'(i)) shadow[i] <= period;
      end
      if (commit) begin
        // Slots beyond this frame's length keep their previous committed value.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (5'(i) < idx) bank[i] <= shadow[i];
        end
        ch_count    <= idx;
        frame_valid <= 1'b1;
        frame_cnt   <= frame_cnt + 16'd1;
      end else if (timeout_hit) begin
        frame_valid <= 1'b0;
`ifdef PPM_FAILSAFE_EN
        ch_count <= NUM_C;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          bank[i] <= 32'(FAILSAFE);
        end
`endif
      end
    end
  end

  // ---------------------------------------------------------------- read port
  always_comb begin
    sel_val = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 4'(i)) sel_val = bank[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ch_value <= '0;
    else        ch_value <= sel_val;
  end

endmodule

// File: tb/tb_ppm_frame_decoder.sv
// Self-checking bench for ppm_frame_decoder: buffer model plus a frame-level
// reference model compared against the DUT on every cycle.
module tb_ppm_frame_decoder;

  localparam int unsigned NUM_CH    = 8;
  localparam int unsigned MIN_CH    = 4;
  localparam int unsigned SYNC_MIN  = 300;
  localparam int unsigned PULSE_MIN = 80;
  localparam int unsigned PULSE_MAX = 250;
  localparam int unsigned TIMEOUT   = 3000;
  localparam int unsigned FAILSAFE  = 170;

  logic        clk, reset, rdy, rd;
  logic [31:0] pulse_data, ch_value;
  logic [3:0]  ch_sel;
  logic [4:0]  ch_count;
  logic        frame_valid, new_frame;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ppm_frame_decoder #(
    .NUM_CH(NUM_CH), .MIN_CH(MIN_CH), .SYNC_MIN(SYNC_MIN), .PULSE_MIN(PULSE_MIN),
    .PULSE_MAX(PULSE_MAX), .TIMEOUT(TIMEOUT), .FAILSAFE(FAILSAFE)
  ) dut (
    .clk(clk), .reset(reset), .rdy(rdy), .pulse_data(pulse_data), .rd(rd),
    .ch_sel(ch_sel), .ch_value(ch_value), .ch_count(ch_count),
    .frame_valid(frame_valid), .new_frame(new_frame),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  int checks = 0;
  int failures = 0;
  int nf_seen = 0;
  int rd_cnt = 0;
  int rd_first = -1;
  int rd_last = -1;
  int cyc = 0;
  bit rand_sel = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  logic [31:0] buf_q[$];
  logic [31:0] pend_word;
  bit          pend = 0;

  longint m_hi, m_bank[16], m_ch[$];
  bit     m_hi_ok, m_run, m_valid, m_newf;
  longint m_count, m_fcnt, m_ecnt, m_idle;

  function automatic void m_reset();
    m_hi = 0; m_hi_ok = 0; m_run = 0; m_valid = 0; m_newf = 0;
    m_count = 0; m_fcnt = 0; m_ecnt = 0; m_idle = 0;
    m_ch.delete();
    for (int i = 0; i < 16; i++) m_bank[i] = 0;
  endfunction

  function automatic void m_bump();
    if (m_ecnt < 255) m_ecnt++;
  endfunction

  function automatic void m_word(input logic [31:0] w);
    longint len, p;
    len = longint'(w[30:0]);
    if (w[31] && !m_hi_ok) begin
      m_hi = len; m_hi_ok = 1;
    end else if (!w[31] && m_hi_ok) begin
      p = m_hi + len;
      if (p > 64'h7FFF_FFFF) p = 64'h7FFF_FFFF;
      m_hi_ok = 0;
      if (p >= SYNC_MIN) begin
        if (m_run) begin
          if (m_ch.size() >= MIN_CH) begin
            for (int i = 0; i < m_ch.size(); i++) m_bank[i] = m_ch[i];
            m_count = m_ch.size(); m_valid = 1; m_newf = 1;
            m_fcnt = (m_fcnt + 1) % 65536;
          end else m_bump();
        end
        m_ch.delete(); m_run = 1;
      end else if (m_run) begin
        if (p >= PULSE_MIN && p <= PULSE_MAX && m_ch.size() < NUM_CH) m_ch.push_back(p);
        else begin m_bump(); m_run = 0; end
      end
    end else begin
      m_bump(); m_hi_ok = 0; m_run = 0;
    end
  endfunction

  function automatic void m_timeout();
    m_valid = 0; m_run = 0; m_hi_ok = 0;
`ifdef PPM_FAILSAFE_EN
    m_count = NUM_CH;
    for (int i = 0; i < NUM_CH; i++) m_bank[i] = FAILSAFE;
`endif
  endfunction

  // Buffer with one cycle of read latency; the model steps once per clock edge.
  initial begin : buffer_and_model
    bit rd_s;
    rdy = 1'b0; pulse_data = '0;
    m_reset();
    forever begin
      @(negedge clk); rd_s = rd;
      @(posedge clk); #1;
      m_newf = 0;
      if (!reset) begin
        m_reset(); pend = 0;
      end else if (pend) begin
        m_word(pend_word); pend = 0; m_idle = 0;
      end else if (m_idle < TIMEOUT) begin
        m_idle++;
        if (m_idle == TIMEOUT) m_timeout();
      end
      if (rd_s && buf_q.size() != 0) begin
        pend_word = buf_q.pop_front(); pulse_data = pend_word; pend = 1;
      end
      rdy = (buf_q.size() != 0);
    end
  end

  // ---------------------------------------------------------------- per-cycle compare
  initial begin : compare
    longint snap;
    bit rd_prev;
    snap = 0; rd_prev = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        chk("rst_rd", rd, 0);           chk("rst_ch_value", ch_value, 0);
        chk("rst_ch_count", ch_count, 0); chk("rst_frame_valid", frame_valid, 0);
        chk("rst_new_frame", new_frame, 0); chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        snap = 0; rd_prev = 0;
      end else begin
        chk("rd_in_cap", rd && rd_prev, 0);
        chk("rd_without_rdy", rd && !rdy, 0);
        chk("new_frame", new_frame, m_newf);
        chk("frame_cnt", frame_cnt, m_fcnt);
        chk("ch_count", ch_count, m_count);
        chk("frame_valid", frame_valid, m_valid);
        chk("err_cnt", err_cnt, m_ecnt);
        chk("ch_value", ch_value, snap);
        snap = (ch_sel < NUM_CH) ? m_bank[ch_sel] : 0;
        rd_prev = rd;
        if (new_frame) nf_seen++;
        if (rd) begin
          rd_cnt++;
          if (rd_first < 0) rd_first = cyc;
          rd_last = cyc;
        end
      end
    end
  end

  initial begin : sel_randomizer
    forever begin
      @(posedge clk); #3;
      if (rand_sel) ch_sel = 4'($urandom_range(0, 15));
    end
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic pair(input int unsigned h, input int unsigned l);
    buf_q.push_back({1'b1, 31'(h)});
    buf_q.push_back({1'b0, 31'(l)});
  endtask

  task automatic chans(input int unsigned n, input int unsigned h, input int unsigned l);
    for (int unsigned i = 0; i < n; i++) pair(h, l);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((buf_q.size() != 0 || pend) && n < 5000) begin
      @(posedge clk); n++;
    end
    chk("drain_bound_expired", n >= 5000, 0);
    repeat (4) @(posedge clk);
    #3;
  endtask

  task automatic read_sel(input int unsigned s, input longint exp);
    ch_sel = 4'(s);
    repeat (2) @(posedge clk);
    #3;
    chk($sformatf("lit_ch_value[%0d]", s), ch_value, exp);
  endtask

  task automatic lit_state(input string tag, input longint fc, input longint ec, input longint cc);
    chk({tag, "_frame_cnt"}, frame_cnt, fc);  chk({tag, "_model_fcnt"}, m_fcnt, fc);
    chk({tag, "_err_cnt"}, err_cnt, ec);      chk({tag, "_model_ecnt"}, m_ecnt, ec);
    chk({tag, "_ch_count"}, ch_count, cc);    chk({tag, "_model_count"}, m_count, cc);
  endtask

  // ---------------------------------------------------------------- directed + random
  initial begin : stim
    int n;
    int unsigned nch, s, h, p, r;
    reset = 1'b0; ch_sel = '0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #3;
    lit_state("after_reset", 0, 0, 0);

    // Normal frame: sync, 8 channels of 150, sync.
    nf_seen = 0;
    pair(400, 40); chans(8, 110, 40); pair(400, 40);
    drain();
    chk("normal_nf_pulses", nf_seen, 1);
    chk("normal_frame_valid", frame_valid, 1);
    lit_state("normal", 1, 0, 8);
    for (int unsigned i = 0; i < 9; i++) read_sel(i, (i < NUM_CH) ? 150 : 0);
    read_sel(15, 0);

    // Read handshake: 10 words queued at once.
    rd_cnt = 0; rd_first = -1; rd_last = -1;
    chans(5, 110, 40);
    drain();
    chk("hs_pops", rd_cnt, 10);
    chk("hs_span", rd_last - rd_first, 18);

    // Out-of-range channel 3 kills the frame; the next clean frame commits.
    pair(400, 40); drain();
    lit_state("pre_oor", 2, 0, 5);
    chans(3, 110, 40); pair(15, 5); chans(4, 110, 40); pair(400, 40);
    drain();
    lit_state("oor", 2, 1, 5);
    chans(8, 100, 30); pair(400, 40);
    drain();
    lit_state("oor_recover", 3, 1, 8);
    read_sel(2, 130);

    // Short frame, then an over-long frame.
    chans(3, 110, 40); pair(400, 40); drain();
    lit_state("short", 3, 2, 8);
    chans(9, 110, 40); pair(400, 40); drain();
    lit_state("long", 3, 3, 8);

    // Saturating sum acts as a sync and commits a 5-channel frame.
    chans(5, 120, 60); pair(32'h7FFF_FFF0, 32'h7FFF_FFF0); drain();
    lit_state("sat", 4, 3, 5);
    read_sel(0, 180);
    read_sel(6, 130);

    // Low level without a preceding high is a decode error.
    buf_q.push_back({1'b0, 31'd40}); drain();
    chk("lone_low_err", err_cnt, 4);

    // Signal loss.
    ch_sel = 4'd0;
    repeat (TIMEOUT + 20) @(posedge clk);
    #3;
    chk("to_frame_valid", frame_valid, 0);
    chk("to_model_valid", m_valid, 0);
`ifdef PPM_FAILSAFE_EN
    chk("to_ch_value", ch_value, FAILSAFE);
    chk("to_ch_count", ch_count, NUM_CH);
`else
    chk("to_ch_value", ch_value, 180);
    chk("to_ch_count", ch_count, 5);
`endif

    // Randomized frames with boundary periods and occasional repeated levels.
    rand_sel = 1;
    for (int unsigned f = 0; f < 30; f++) begin
      nch = $urandom_range(2, 10);
      s = $urandom_range(300, 700);
      h = $urandom_range(50, s - 20);
      pair(h, s - h);
      for (int unsigned c = 0; c < nch; c++) begin
        r = $urandom_range(0, 19);
        case (r)
          0: p = 79;
          1: p = 80;
          2: p = 250;
          3: p = 251;
          4: p = $urandom_range(20, 79);
          5: begin buf_q.push_back({1'b1, 31'd60}); p = $urandom_range(80, 250); end
          default: p = $urandom_range(80, 250);
        endcase
        h = $urandom_range(1, p - 1);
        pair(h, p - h);
      end
      if (f % 5 == 4) drain();
    end
    pair(400, 40);
    drain();
    rand_sel = 0;

    // Reset while the decoder is waiting on a popped word.
    pair(400, 40); chans(4, 110, 40);
    n = 0;
    do begin @(negedge clk); n++; end while (!rd && n < 100);
    chk("midop_rd_seen", rd, 1);
    @(posedge clk); #3;
    reset = 1'b0;
    buf_q.delete();
    #1;
    chk("midop_rd", rd, 0);
    chk("midop_frame_cnt", frame_cnt, 0);
    chk("midop_ch_value", ch_value, 0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    nf_seen = 0;
    pair(400, 40); chans(8, 110, 40); pair(400, 40); chans(8, 110, 40);
    drain();
    chk("midop_nf_pulses", nf_seen, 1);
    lit_state("midop", 1, 0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation_time_limit_reached");
    $fatal(1, "watchdog");
  end

endmodule
